// File: rtl/multi_chan_accel_core.sv
// multi_chan_accel_core
// Multi-channel iterative datapath. A command names a channel, an op, an operand
// and an iteration count. The op is applied to a captured data word once per
// cycle, and the result is handed back through a wen/ack write-back. Accepted
// results are also stored in a per-channel bank that the register block can read.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start_i; err_code_o holds the last error
// S_BUSY  | applying the op once per cycle, cnt counting down to 1
// S_DONE  | result presented on data_o/ch_o with wen_o high until ack_i
// S_ERROR | one-cycle error indication, then back to S_IDLE
module multi_chan_accel_core #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 4,
  parameter int ITER_WIDTH = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CH_W-1:0]       ch_sel_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ITER_WIDTH-1:0] iter_i,
  input  logic                  abort_i,
  input  logic                  ack_i,
  input  logic [CH_W-1:0]       rd_ch_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CH_W-1:0]       ch_o,
  output logic                  wen_o,
  output logic [1:0]            status_o,
  output logic [1:0]            err_code_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int SH_W = $clog2(DATA_WIDTH);
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_XOR = 2'd1;
  localparam logic [1:0] OP_ROL = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  // State encoding doubles as the status_o encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  state_e                state;
  logic [CH_W-1:0]       ch_q;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] operand_q;
  logic [DATA_WIDTH-1:0] acc;
  logic [ITER_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] bank [NUM_CH];

  logic                    bad_cmd;
  logic [2*DATA_WIDTH-1:0] rot;
  logic [DATA_WIDTH-1:0]   op_res;

  assign bad_cmd = ({1'b0, ch_sel_i} >= NUM_CH_V) || (op_i == 2'd3) || (iter_i == '0);

  // Rotating a doubled word left leaves the rotated value in the upper half.
  assign rot = {acc, acc} << operand_q[SH_W-1:0];

  // One application of the captured op to the accumulator.
  always_comb begin
    op_res = acc;
    case (op_q)
      OP_ADD:  op_res = acc + operand_q;
      OP_XOR:  op_res = acc ^ operand_q;
      OP_ROL:  op_res = rot[2*DATA_WIDTH-1:DATA_WIDTH];
      default: op_res = acc;
    endcase
  end

  // Sequencer: command capture, iteration, write-back handshake and error codes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      status_o   <= S_IDLE;
      ch_q       <= '0;
      op_q       <= '0;
      operand_q  <= '0;
      acc        <= '0;
      cnt        <= '0;
      data_o     <= '0;
      ch_o       <= '0;
      wen_o      <= 1'b0;
      err_code_o <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            ch_q      <= ch_sel_i;
            op_q      <= op_i;
            operand_q <= operand_i;
            acc       <= data_i;
            cnt       <= iter_i;
            if (bad_cmd) begin
              state      <= S_ERROR;
              status_o   <= S_ERROR;
              err_code_o <= ERR_BAD_CMD;
            end else begin
              state      <= S_BUSY;
              status_o   <= S_BUSY;
              err_code_o <= ERR_NONE;
            end
          end
        end
        S_BUSY: begin
          if (start_i) err_code_o <= ERR_OVERRUN;
          // Abort takes priority even over the final iteration.
          if (abort_i) begin
            state      <= S_ERROR;
            status_o   <= S_ERROR;
            err_code_o <= ERR_ABORT;
          end else begin
            acc <= op_res;
            cnt <= cnt - 1'b1;
            if (cnt == ITER_WIDTH'(1)) begin
              state    <= S_DONE;
              status_o <= S_DONE;
              data_o   <= op_res;
              ch_o     <= ch_q;
              wen_o    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start_i) err_code_o <= ERR_OVERRUN;
          if (ack_i) begin
            wen_o    <= 1'b0;
            state    <= S_IDLE;
            status_o <= S_IDLE;
          end
        end
        default: begin
          if (start_i) err_code_o <= ERR_OVERRUN;
          state    <= S_IDLE;
          status_o <= S_IDLE;
        end
      endcase
    end
  end

  // Result bank: an entry is written only when its write-back is acknowledged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
    end else if (state == S_DONE && ack_i) begin
      bank[ch_q] <= acc;
    end
  end

  // Registered bank read; a same-cycle write shows up one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_o <= '0;
    end else if ({1'b0, rd_ch_i} < NUM_CH_V) begin
      rd_data_o <= bank[rd_ch_i];
    end else begin
      rd_data_o <= '0;
    end
  end

endmodule

// File: tb/tb_multi_chan_accel_core.sv
// Directed bench for multi_chan_accel_core, built with three channels so that an
// out-of-range channel select is reachable.
module tb_multi_chan_accel_core;

  localparam int DW = 64;
  localparam int NC = 3;
  localparam int IW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] ch_sel;
  logic [1:0]    op;
  logic [DW-1:0] operand;
  logic [DW-1:0] data;
  logic [IW-1:0] iter;
  logic          abort;
  logic          ack;
  logic [CW-1:0] rd_ch;
  logic [DW-1:0] data_out;
  logic [CW-1:0] ch_out;
  logic          wen;
  logic [1:0]    status;
  logic [1:0]    err_code;
  logic [DW-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  multi_chan_accel_core #(.DATA_WIDTH(DW), .NUM_CH(NC), .ITER_WIDTH(IW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .ch_sel_i   (ch_sel),
    .op_i       (op),
    .operand_i  (operand),
    .data_i     (data),
    .iter_i     (iter),
    .abort_i    (abort),
    .ack_i      (ack),
    .rd_ch_i    (rd_ch),
    .data_o     (data_out),
    .ch_o       (ch_out),
    .wen_o      (wen),
    .status_o   (status),
    .err_code_o (err_code),
    .rd_data_o  (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [CW-1:0] c, input logic [1:0] o, input logic [DW-1:0] opd,
                     input logic [DW-1:0] d, input logic [IW-1:0] n);
    start = 1'b1; ch_sel = c; op = o; operand = opd; data = d; iter = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_wen();
    int n = 0;
    while (!wen && n < 40) begin
      tick();
      n++;
    end
    if (!wen) begin
      checks++;
      errors++;
      $error("FAIL wen_timeout observed wen_o=0 expected 1");
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ch_sel = '0; op = '0; operand = '0; data = '0;
    iter = '0; abort = 1'b0; ack = 1'b0; rd_ch = '0;
    #12;
    chk("rst_status", status, 0);
    chk("rst_wen", wen, 0);
    chk("rst_data", data_out, 0);
    chk("rst_err", err_code, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    tick();

    // ADD ch1, 0x10 + 3*5, with latency check
    rd_ch = 2'd1;
    cmd(2'd1, 2'd0, 64'h5, 64'h10, 8'd3);
    chk("t1_status_busy", status, 1);
    tick();
    chk("t1_wen_early1", wen, 0);
    tick();
    chk("t1_wen_early2", wen, 0);
    tick();
    chk("t1_wen", wen, 1);
    chk("t1_data", data_out, 64'h1F);
    chk("t1_ch", ch_out, 1);
    chk("t1_status_done", status, 2);
    do_ack();
    chk("t1_wen_off", wen, 0);
    chk("t1_status_idle", status, 0);
    chk("t1_rd_old", rd_data, 0);
    tick();
    chk("t1_rd_new", rd_data, 64'h1F);

    // ADD wraparound
    cmd(2'd0, 2'd0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1);
    tick();
    chk("t2_wrap_wen", wen, 1);
    chk("t2_wrap_data", data_out, 0);
    do_ack();

    // XOR twice returns the original
    cmd(2'd2, 2'd1, 64'hFF, 64'hA5, 8'd2);
    wait_wen();
    chk("t2_xor_data", data_out, 64'hA5);
    chk("t2_xor_ch", ch_out, 2);
    do_ack();

    // ROL by 4
    cmd(2'd0, 2'd2, 64'h4, 64'h8000_0000_0000_0001, 8'd1);
    wait_wen();
    chk("t3_rol", data_out, 64'h18);
    do_ack();

    // Illegal commands
    cmd(2'd0, 2'd0, 64'h1, 64'h1, 8'd0);
    chk("t4_iter0_status", status, 3);
    chk("t4_iter0_err", err_code, 1);
    chk("t4_iter0_wen", wen, 0);
    tick();
    chk("t4_iter0_idle", status, 0);
    chk("t4_iter0_sticky", err_code, 1);
    cmd(2'd0, 2'd3, 64'h1, 64'h1, 8'd1);
    chk("t4_op3_status", status, 3);
    chk("t4_op3_err", err_code, 1);
    tick();
    chk("t4_op3_idle", status, 0);
    cmd(2'd3, 2'd0, 64'h1, 64'h1, 8'd1);
    chk("t4_ch3_status", status, 3);
    chk("t4_ch3_err", err_code, 1);
    chk("t4_ch3_wen", wen, 0);
    tick();
    chk("t4_ch3_idle", status, 0);

    // Overrun while busy
    cmd(2'd1, 2'd0, 64'h1, 64'h100, 8'd4);
    chk("t5_err_cleared", err_code, 0);
    start = 1'b1; ch_sel = 2'd2; op = 2'd1; operand = 64'hFFFF; data = 64'h0; iter = 8'd1;
    tick();
    start = 1'b0;
    chk("t5_overrun_err", err_code, 2);
    chk("t5_overrun_busy", status, 1);
    chk("t5_overrun_wen", wen, 0);
    wait_wen();
    chk("t5_overrun_data", data_out, 64'h104);
    chk("t5_overrun_ch", ch_out, 1);
    do_ack();
    tick();
    chk("t5_overrun_bank", rd_data, 64'h104);
    chk("t5_err_sticky", err_code, 2);

    // Abort mid-busy leaves bank entry untouched
    rd_ch = 2'd2;
    cmd(2'd2, 2'd0, 64'h1, 64'h0, 8'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_status", status, 3);
    chk("t5_abort_err", err_code, 3);
    chk("t5_abort_wen", wen, 0);
    tick();
    chk("t5_abort_idle", status, 0);
    chk("t5_abort_bank", rd_data, 64'hA5);

    // Abort on the final iteration wins
    rd_ch = 2'd0;
    cmd(2'd0, 2'd0, 64'h1, 64'h7, 8'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_last_status", status, 3);
    chk("t5_abort_last_wen", wen, 0);
    chk("t5_abort_last_err", err_code, 3);
    tick();
    chk("t5_abort_last_bank", rd_data, 64'h18);

    // Result held while ack is withheld
    cmd(2'd0, 2'd1, 64'hF, 64'h0, 8'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t6_hold_wen", wen, 1);
      chk("t6_hold_data", data_out, 64'hF);
      tick();
    end
    chk("t6_hold_status", status, 2);
    do_ack();
    chk("t6_ack_idle", status, 0);

    // Reset in the middle of a busy operation, with a nonzero error code
    rd_ch = 2'd1;
    tick();
    chk("t6_pre_rst_rd", rd_data, 64'h104);
    cmd(2'd1, 2'd0, 64'h3, 64'h9, 8'd10);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_pre_rst_err", err_code, 2);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_status", status, 0);
    chk("t6_rst_wen", wen, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_err", err_code, 0);
    chk("t6_rst_rd", rd_data, 0);
    #4;
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_rst_bank", rd_data, 0);
    chk("t6_rst_idle", status, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
